// File: rtl/button_reader.sv
// Debounces two raw push buttons and derives press/release/long-press events plus LED mode state.
// Latency: 2 sync + 2**DEBOUNCE_SIZE cycles from a steady new level to held/press/release; modes follow one cycle later.
// Backpressure: none; event outputs are single-cycle pulses that are never held or queued.
//
// The release pulse port is named rel because "release" is a reserved word in SystemVerilog.
module button_reader #(
    parameter int DEBOUNCE_SIZE = 10,
    parameter int HOLD_SIZE     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] btn_n,
    output logic [1:0] press,
    output logic [1:0] rel,
    output logic [1:0] held,
    output logic [1:0] long_press,
    output logic       reverse,
    output logic [1:0] speed
);

    localparam int HW = DEBOUNCE_SIZE + HOLD_SIZE;

    localparam logic [DEBOUNCE_SIZE-1:0] DB_MAX   = '1;
    localparam logic [DEBOUNCE_SIZE-1:0] DB_ONE   = DEBOUNCE_SIZE'(1);
    localparam logic [HW-1:0]            HOLD_MAX = '1;
    localparam logic [HW-1:0]            HOLD_ONE = HW'(1);
    // Value one step below saturation: the next increment lands on all-ones.
    localparam logic [HW-1:0]            HOLD_PRE = HOLD_MAX - HOLD_ONE;

    // Two-flop synchronizer stages; reset to the released (high) raw level.
    logic [1:0] sync1;
    logic [1:0] sync2;
    // Synchronized level, active-high (1 = pressed).
    logic [1:0] lvl;

    assign lvl = ~sync2;

    // Bring the asynchronous raw buttons into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic                     stable;
        logic [DEBOUNCE_SIZE-1:0] db_cnt;
        logic [HW-1:0]            hold_cnt;
        logic                     flip;
        logic                     press_q;
        logic                     rel_q;
        logic                     long_q;

        // The stable state changes on the edge where a differing level completes its full window.
        assign flip = (lvl[b] != stable) && (db_cnt == DB_MAX);

        // Debounce counter: any agreement with the stable state restarts the window from zero.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stable <= 1'b0;
                db_cnt <= '0;
            end else if (lvl[b] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                stable <= lvl[b];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end

        // Edge pulses registered on the same edge as the stable-state update; flip picks exactly one.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= flip & lvl[b];
                rel_q   <= flip & ~lvl[b];
            end
        end

        // Hold counter: zero while released and on either transition edge, saturating while pressed.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                hold_cnt <= '0;
            end else if (flip || !stable) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end

        // Long-press pulse on the edge the hold counter reaches all-ones; saturation prevents repeats.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                long_q <= 1'b0;
            end else begin
                long_q <= stable && !flip && (hold_cnt == HOLD_PRE);
            end
        end

        assign held[b]       = stable;
        assign press[b]      = press_q;
        assign rel[b]        = rel_q;
        assign long_press[b] = long_q;
    end

    // LED mode state: a long press on either button resets both modes and overrides any press update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reverse <= 1'b0;
            speed   <= 2'd0;
        end else if (|long_press) begin
            reverse <= 1'b0;
            speed   <= 2'd0;
        end else begin
            if (press[0]) begin
                reverse <= ~reverse;
            end
            if (press[1]) begin
                speed <= speed + 2'd1;
            end
        end
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_SIZE, default 10: debounce window is 2**DEBOUNCE_SIZE clock cycles.
REQ-002 SHALL have parameter HOLD_SIZE, default 4: long-press threshold is 2**(DEBOUNCE_SIZE+HOLD_SIZE) cycles.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port btn_n  input  2  raw push buttons, asynchronous to clk, low = pressed.
REQ-006 SHALL have port press  output  2  one-cycle pulse per button on debounced press.
REQ-007 SHALL have port release  output  2  one-cycle pulse per button on debounced release.
REQ-008 SHALL have port held  output  2  debounced pressed level per button, 1 = pressed.
REQ-009 SHALL have port long_press  output  2  one-cycle pulse per button when the hold threshold is reached.
REQ-010 SHALL have port reverse  output  1  LED pattern direction mode, 1 = reverse.
REQ-011 SHALL have port speed  output  2  LED pattern speed select, 0..3.

Function
REQ-012 SHALL pass each btn_n bit through a two-flop synchronizer before any other use; the synchronized level is inverted to active-high.
REQ-013 SHALL keep per button a stable state (reflected on held) and a DEBOUNCE_SIZE-bit counter.
REQ-014 SHALL clear the debounce counter in any cycle where the synchronized level equals the stable state.
REQ-015 SHALL increment the debounce counter in each cycle where the synchronized level differs from the stable state; when the counter is 2**DEBOUNCE_SIZE-1 and still differing, the stable state SHALL take the new level and the counter SHALL clear at that edge.
REQ-016 SHALL make the latency exact: with a new level present before clock edge 1 and held steady, held changes and press/release asserts after edge 2+2**DEBOUNCE_SIZE.
REQ-017 SHALL treat any glitch shorter than 2**DEBOUNCE_SIZE synchronized cycles as no event; counter restarts from 0.
REQ-018 SHALL register press and release in the same edge as the stable-state update, each high for exactly one cycle.
REQ-019 SHALL keep per button a (DEBOUNCE_SIZE+HOLD_SIZE)-bit hold counter: 0 while not pressed and on the press edge, increments each cycle while held=1, saturates at all-ones.
REQ-020 SHALL pulse long_press for one cycle on the edge the hold counter becomes all-ones; no further pulse until release and a new press.
REQ-021 SHALL toggle reverse one cycle after press[0] (registered from press[0]).
REQ-022 SHALL increment speed modulo 4 (3 -> 0) one cycle after press[1].
REQ-023 SHALL clear reverse and speed to 0 one cycle after long_press on either button; clear SHALL win over a toggle or increment in the same cycle.
REQ-024 SHALL handle both buttons independently; simultaneous press[0] and press[1] SHALL apply both mode updates in the same cycle.
REQ-025 SHALL never assert press and release of the same button in the same cycle.

Reset
REQ-026 SHALL, on rstn low, asynchronously clear synchronizers to released, stable states, all counters, press, release, held, long_press, reverse and speed to 0.
REQ-027 SHALL, on reset mid-debounce or mid-hold, discard the partial count; a button still pressed after reset release SHALL be re-debounced from 0 and produce a normal press.
REQ-028 SHALL require rstn deassertion synchronous to clk; the block SHALL start counting on the first edge after deassertion.

Verification (DEBOUNCE_SIZE=2, HOLD_SIZE=2 unless stated)
REQ-029 SHALL cover clean press: btn_n[0] 1->0 before edge 1, held low -> held[0]=1 and press[0]=1 for one cycle after edge 6; reverse=1 after edge 7.
REQ-030 SHALL cover bounce: btn_n[1] low for 3 cycles, high 2, then low steady -> no press during bounce, single press[1] 6 edges after the final low, speed 0->1.
REQ-031 SHALL cover long press: btn_n[0] held low -> long_press[0] one cycle, 15 edges after press[0]; reverse and speed both 0 one cycle later; no second pulse while held.
REQ-032 SHALL cover speed wrap: four debounced presses of button 1 -> speed 1,2,3,0.
REQ-033 SHALL cover simultaneous: both buttons pressed same cycle -> press=2'b11 in one cycle, then reverse toggles and speed increments together.
REQ-034 SHALL cover reset mid-operation: rstn low during debounce count 2 and with reverse=1 -> all outputs 0 immediately; button still low after release -> press 6 edges after the first post-reset edge.
